boot_image_sender: RTL and testbench

- Host-side counterpart of the UART boot loader. Streams a program image of WORDS 16-bit words from a synchronous ROM as bytes to a UART transmitter, then asserts the scan request.
- Collects the echoed dump bytes from a UART receiver, reassembles them into words and compares each against the ROM.
- Used as the bench/board-side uploader and as a self-checking loopback partner.

---
 rtl/boot_image_if.sv | 12 +
 rtl/boot_image_sender.sv | 162 ++++++++++++++++
 tb/tb_boot_image_sender.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_image_if.sv
// boot_image_if: ROM read port plus UART tx/rx byte channels of boot_image_sender
interface boot_image_if #(parameter int ADR_W = 6);
  logic [ADR_W-1:0] rom_adr;
  logic [15:0] rom_data;
  logic [7:0] tx_dat;
  logic tx_en;
  logic tx_full;
  logic [7:0] rx_dat;
  logic rx_en;
  modport master(output rom_adr, tx_dat, tx_en, input rom_data, tx_full, rx_dat, rx_en);
  modport slave(input rom_adr, tx_dat, tx_en, output rom_data, tx_full, rx_dat, rx_en);
endinterface

// File: rtl/boot_image_sender.sv
// boot_image_sender: streams a ROM image as bytes to a UART, then pulses scan_req.
// Define BOOT_VERIFY_EN to also read back the echoed dump and compare it with the ROM.
module boot_image_sender #(
  parameter int WORDS = 64,
  parameter int ADR_W = 6,
  parameter int GAP_CYCLES = 2000,
  parameter int RX_TIMEOUT = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic start,
  boot_image_if.master bus,
  output logic scan_req,
  output logic busy,
  output logic done,
  output logic [6:0] err_count,
  output logic [ADR_W-1:0] first_err_adr,
  output logic timeout,
  output logic overrun
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [3:0] {
    IDLE, FETCH, SEND_HI, GAP_HI, SEND_LO, GAP_LO, NEXT,
    SCAN, RECV_HI, RECV_LO, CMP_WAIT, COMPARE, DONE
  } state_t;
  state_t state;
  logic [ADR_W-1:0] wcnt;
  logic [GW-1:0] gcnt;
  logic [15:0] shadow;
  logic dly, last, gap_end;
  // the word counter doubles as the ROM address, so the ROM always sees the current word
  assign bus.rom_adr = wcnt;
  assign last = wcnt == ADR_W'(WORDS - 1);
  assign gap_end = gcnt == GW'(GAP_CYCLES - 1);
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
`ifdef BOOT_VERIFY_EN
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic [7:0] hold, rx_hi, rx_lo;
  logic pend, take, tout;
  assign take = ce && pend && (state == RECV_HI || state == RECV_LO);
  assign tout = tcnt == TW'(RX_TIMEOUT - 1);
`else
  logic [40:0] unused_rx;
  assign unused_rx = {bus.rx_dat, bus.rx_en, 32'(RX_TIMEOUT)};
  assign err_count = '0;
  assign first_err_adr = '0;
  assign timeout = 1'b0;
  assign overrun = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      gcnt <= '0;
      dly <= 1'b0;
      shadow <= '0;
      bus.tx_dat <= '0;
      bus.tx_en <= 1'b0;
      scan_req <= 1'b0;
`ifdef BOOT_VERIFY_EN
      tcnt <= '0;
      hold <= '0;
      rx_hi <= '0;
      rx_lo <= '0;
      pend <= 1'b0;
      err_count <= '0;
      first_err_adr <= '0;
      timeout <= 1'b0;
      overrun <= 1'b0;
`endif
    end else begin
      bus.tx_en <= 1'b0;
      if (ce)
        case (state)
          IDLE: begin
            wcnt <= '0;
`ifdef BOOT_VERIFY_EN
            err_count <= '0;
            first_err_adr <= '0;
            timeout <= 1'b0;
            overrun <= 1'b0;
`endif
            if (start) state <= FETCH;
          end
          FETCH: begin
            dly <= !dly;
            if (dly) begin
              shadow <= bus.rom_data;
              state <= SEND_HI;
            end
          end
          SEND_HI, SEND_LO:
            if (!bus.tx_full) begin
              bus.tx_en <= 1'b1;
              bus.tx_dat <= state == SEND_HI ? shadow[15:8] : shadow[7:0];
              state <= state == SEND_HI ? GAP_HI : GAP_LO;
            end
          GAP_HI, GAP_LO: begin
            gcnt <= gap_end ? '0 : gcnt + 1'b1;
            if (gap_end) state <= state == GAP_HI ? SEND_LO : NEXT;
          end
          NEXT: begin
            wcnt <= last ? '0 : wcnt + 1'b1;
            scan_req <= last;
            state <= last ? SCAN : FETCH;
          end
`ifdef BOOT_VERIFY_EN
          SCAN, RECV_HI, RECV_LO:
            if (take) begin
              tcnt <= '0;
              if (state == RECV_HI) begin
                rx_hi <= hold;
                scan_req <= 1'b0;
                state <= RECV_LO;
              end else begin
                rx_lo <= hold;
                state <= CMP_WAIT;
              end
            end else if (tout) begin
              tcnt <= '0;
              timeout <= 1'b1;
              scan_req <= 1'b0;
              state <= DONE;
            end else begin
              tcnt <= tcnt + 1'b1;
              if (state == SCAN) state <= RECV_HI;
            end
          CMP_WAIT: begin
            dly <= !dly;
            if (dly) state <= COMPARE;
          end
          COMPARE: begin
            if ({rx_hi, rx_lo} != bus.rom_data) begin
              if (err_count == 7'd0) first_err_adr <= wcnt;
              if (err_count != 7'd127) err_count <= err_count + 1'b1;
            end
            wcnt <= last ? wcnt : wcnt + 1'b1;
            state <= last ? DONE : RECV_HI;
          end
`else
          SCAN: begin
            scan_req <= 1'b0;
            state <= DONE;
          end
`endif
          DONE: if (!start) state <= IDLE;
          default: state <= IDLE;
        endcase
`ifdef BOOT_VERIFY_EN
      // capture runs every clk; a byte landing while one is still pending is an overrun
      if (bus.rx_en) begin
        hold <= bus.rx_dat;
        pend <= 1'b1;
        if (pend && !take) overrun <= 1'b1;
      end else if (take)
        pend <= 1'b0;
`endif
    end
endmodule

// File: tb/tb_boot_image_sender.sv
// tb_boot_image_sender: scoreboard bench for boot_image_sender (4-word image, short gap and timeout)
module tb_boot_image_sender;
  localparam int WORDS = 4, ADR_W = 6, GAP = 3, TMO = 100;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b1, start = 1'b0;
  logic scan_req, busy, done, timeout, overrun;
  logic [6:0] err_count;
  logic [ADR_W-1:0] first_err_adr;
  logic [15:0] rom [64];
  logic [7:0] exp_tx [$];
  logic [7:0] exp_b;
  int checks = 0, errors = 0, cyc = 0, last_tx = -1;

  boot_image_if #(.ADR_W(ADR_W)) bus();
  boot_image_sender #(.WORDS(WORDS), .ADR_W(ADR_W), .GAP_CYCLES(GAP), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .bus(bus),
    .scan_req(scan_req), .busy(busy), .done(done), .err_count(err_count),
    .first_err_adr(first_err_adr), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_adr];

  // tx scoreboard: every strobe pops the next expected byte and must keep its distance
  always @(negedge clk) begin
    cyc++;
    if (!busy) last_tx = -1;
    if (bus.tx_en === 1'b1) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_extra got %h expected none", bus.tx_dat);
      end else begin
        exp_b = exp_tx.pop_front();
        if (bus.tx_dat !== exp_b) begin
          errors++;
          $display("FAIL tx_byte got %h expected %h", bus.tx_dat, exp_b);
        end
      end
      if (last_tx >= 0) begin
        checks++;
        if (cyc - last_tx < GAP + 1) begin
          errors++;
          $display("FAIL tx_gap got %0d expected >= %0d", cyc - last_tx, GAP + 1);
        end
      end
      last_tx = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] img(input int k);
    return k[0] ? 8'hB0 + 8'(k / 2) : 8'hA0;
  endfunction

  task automatic push_image();
    for (int k = 0; k < 2 * WORDS; k++) exp_tx.push_back(img(k));
  endtask

  task automatic wait_scan(output int n);
    n = 0;
    while (scan_req !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dat = b;
    bus.rx_en = 1'b1;
    @(negedge clk);
    bus.rx_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic echo(input int from, input int upto, input int bad);
    for (int k = from; k < upto; k++) send_rx(k == bad ? 8'hFF : img(k));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({scan_req, busy, done, timeout, overrun, err_count, first_err_adr, bus.tx_en, bus.tx_dat, bus.rom_adr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 0", {scan_req, busy, done, timeout, overrun, err_count, first_err_adr, bus.tx_en, bus.tx_dat, bus.rom_adr});
    end
    rst = 1'b0;
  endtask

  task automatic test_upload();
    int n;
    push_image();
    @(negedge clk);
    start = 1'b1;
    wait_scan(n);
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL scan_wait got none expected scan_req"); end
    checks++;
    if (exp_tx.size() != 0) begin errors++; $display("FAIL tx_count got %0d left expected 0", exp_tx.size()); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_scan got %b expected 1", busy); end
    @(negedge clk);
`ifdef BOOT_VERIFY_EN
    checks++;
    if (scan_req !== 1'b1) begin errors++; $display("FAIL scan_hold got %b expected 1", scan_req); end
    bus.rx_dat = 8'hA0;
    bus.rx_en = 1'b1;
    @(negedge clk);
    bus.rx_en = 1'b0;
    checks++;
    if (scan_req !== 1'b1) begin errors++; $display("FAIL scan_before_take got %b expected 1", scan_req); end
    @(negedge clk);
    checks++;
    if (scan_req !== 1'b0) begin errors++; $display("FAIL scan_after_take got %b expected 0", scan_req); end
    repeat (4) @(negedge clk);
    echo(1, 2 * WORDS, -1);
    wait_done(n);
    checks++;
    if ({done, err_count, timeout, overrun} !== {1'b1, 7'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL echo_ok got done=%b err=%0d to=%b ov=%b expected 1 0 0 0", done, err_count, timeout, overrun);
    end
`else
    checks++;
    if ({scan_req, done} !== 2'b01) begin errors++; $display("FAIL scan_pulse got scan=%b done=%b expected 0 1", scan_req, done); end
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b expected 1", done); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL back_idle got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_ce_gate();
    ce = 1'b0;
    start = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ce_gate got busy=%b expected 0", busy); end
    start = 1'b0;
    @(negedge clk);
    ce = 1'b1;
  endtask

  task automatic test_tx_full();
    int n, k, bad;
    push_image();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    k = 0;
    while (k < 3 && n < 1000) begin @(negedge clk); n++; if (bus.tx_en === 1'b1) k++; end
    checks++;
    if (k < 3) begin errors++; $display("FAIL full_pre got %0d strobes expected 3", k); end
    bus.tx_full = 1'b1;
    bad = 0;
    repeat (50) begin @(negedge clk); if (bus.tx_en !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_withhold got %0d strobes expected 0", bad); end
    bus.tx_full = 1'b0;
    wait_scan(n);
    checks++;
    if (n >= 1000 || exp_tx.size() != 0) begin errors++; $display("FAIL full_rest got %0d left expected 0", exp_tx.size()); end
    wait_done(n);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b expected 1", done); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef BOOT_VERIFY_EN
  task automatic test_mismatch();
    int n;
    push_image();
    @(negedge clk);
    start = 1'b1;
    wait_scan(n);
    echo(0, 2 * WORDS, 5);
    wait_done(n);
    checks++;
    if ({done, err_count, first_err_adr, timeout} !== {1'b1, 7'd1, 6'd2, 1'b0}) begin
      errors++;
      $display("FAIL mismatch got done=%b err=%0d adr=%0d to=%b expected 1 1 2 0", done, err_count, first_err_adr, timeout);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    push_image();
    @(negedge clk);
    start = 1'b1;
    wait_scan(n);
    echo(0, 2, -1);
    @(negedge clk);
    bus.rx_dat = 8'hA0;
    bus.rx_en = 1'b1;
    @(negedge clk);
    bus.rx_en = 1'b0;
    wait_done(n);
    checks++;
    if (n < TMO - 2 || n > TMO + 4) begin errors++; $display("FAIL timeout_delay got %0d expected about %0d", n, TMO + 1); end
    checks++;
    if ({done, timeout, err_count} !== {1'b1, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL timeout_flags got done=%b to=%b err=%0d expected 1 1 0", done, timeout, err_count);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun();
    int n;
    ce = 1'b0;
    @(negedge clk);
    bus.rx_dat = 8'h11;
    bus.rx_en = 1'b1;
    @(negedge clk);
    bus.rx_dat = 8'hA0;
    @(negedge clk);
    bus.rx_en = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b expected 1", overrun); end
    ce = 1'b1;
    push_image();
    start = 1'b1;
    wait_scan(n);
    echo(1, 2 * WORDS, -1);
    wait_done(n);
    checks++;
    if ({done, err_count, overrun, timeout} !== {1'b1, 7'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL overrun_keep got done=%b err=%0d ov=%b to=%b expected 1 0 0 0", done, err_count, overrun, timeout);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`else
  task automatic test_tied();
    bus.rx_dat = 8'h5A;
    bus.rx_en = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({err_count, first_err_adr, timeout, overrun} !== '0) begin
      errors++;
      $display("FAIL tied_outputs got err=%0d adr=%0d to=%b ov=%b expected 0", err_count, first_err_adr, timeout, overrun);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n, k;
    push_image();
    @(negedge clk);
    start = 1'b1;
    n = 0;
    k = 0;
    while (k < 1 && n < 1000) begin @(negedge clk); n++; if (bus.tx_en === 1'b1) k++; end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({scan_req, busy, done, timeout, overrun, err_count, first_err_adr, bus.tx_en, bus.tx_dat, bus.rom_adr} !== '0) begin
      errors++;
      $display("FAIL reset_mid got %b expected 0", {scan_req, busy, done, timeout, overrun, err_count, first_err_adr, bus.tx_en, bus.tx_dat, bus.rom_adr});
    end
    exp_tx.delete();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_image();
    @(negedge clk);
    start = 1'b1;
    wait_scan(n);
    checks++;
    if (n >= 1000 || exp_tx.size() != 0) begin errors++; $display("FAIL reupload got %0d left expected 0", exp_tx.size()); end
    wait_done(n);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.tx_full = 1'b0;
    bus.rx_en = 1'b0;
    bus.rx_dat = '0;
    for (int i = 0; i < 64; i++) rom[i] = 16'hA0B0 + 16'(i);
    test_reset();
    test_upload();
    test_ce_gate();
    test_tx_full();
`ifdef BOOT_VERIFY_EN
    test_mismatch();
    test_timeout();
    test_overrun();
`else
    test_tied();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
